// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter that shares one L2 cache port between the I-cache refill (port 0)
// and the D-cache refill/write-through (port 1), with a watchdog on stalled reads.
module l2_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         p0_req,
    input  logic         p0_we,
    input  logic [31:0]  p0_addr,
    input  logic [31:0]  p0_wdata,
    output logic         p0_ack,
    output logic [127:0] p0_rdata,
    input  logic         p1_req,
    input  logic         p1_we,
    input  logic [31:0]  p1_addr,
    input  logic [31:0]  p1_wdata,
    output logic         p1_ack,
    output logic [127:0] p1_rdata,
    output logic         l2_read_index,
    output logic         l2_write_index,
    output logic [31:0]  l2_addr,
    output logic [31:0]  l2_write_data,
    input  logic         l2_stall,
    input  logic [127:0] l2_block,
    output logic         busy,
    output logic         grant_id,
    output logic         timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic            lastGrant_q, lastGrant_d;
    logic            grantId_q, grantId_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [127:0]    rdata0_q, rdata0_d;
    logic [127:0]    rdata1_q, rdata1_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            timeoutErr_q, timeoutErr_d;
    logic            grantSel;
    logic            grantWe;

    // lastGrant resets to 1 so that port 0 wins the very first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            lastGrant_q  <= 1'b1;
            grantId_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            wdog_q       <= '0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lastGrant_q  <= lastGrant_d;
            grantId_q    <= grantId_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            wdog_q       <= wdog_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        lastGrant_d    = lastGrant_q;
        grantId_d      = grantId_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata0_d       = rdata0_q;
        rdata1_d       = rdata1_q;
        wdog_d         = wdog_q;
        timeoutErr_d   = timeoutErr_q;
        grantSel       = 1'b0;
        grantWe        = 1'b0;
        l2_read_index  = 1'b0;
        l2_write_index = 1'b0;
        p0_ack         = 1'b0;
        p1_ack         = 1'b0;

        case (state_q)
            IDLE: begin
                grantSel = (p0_req && p1_req) ? ~lastGrant_q : p1_req;
                grantWe  = grantSel ? p1_we : p0_we;
                if (p0_req || p1_req) begin
                    grantId_d   = grantSel;
                    lastGrant_d = grantSel;
                    addr_d      = grantSel ? p1_addr : p0_addr;
                    wdata_d     = grantSel ? p1_wdata : p0_wdata;
                    wdog_d      = '0;
                    state_d     = grantWe ? WR : RD;
                end
            end

            RD: begin
                l2_read_index = 1'b1;
                if (!l2_stall) begin
                    if (grantId_q) rdata1_d = l2_block;
                    else           rdata0_d = l2_block;
                    state_d = RESP;
                end else if (wdog_q == WD_LIMIT) begin
                    // Abort: the requester still gets its ack, with an all-zero block.
                    timeoutErr_d = 1'b1;
                    if (grantId_q) rdata1_d = '0;
                    else           rdata0_d = '0;
                    state_d = RESP;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            WR: begin
                l2_write_index = 1'b1;
                state_d        = RESP;
            end

            RESP: begin
                p0_ack  = ~grantId_q;
                p1_ack  = grantId_q;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign grant_id      = grantId_q;
    assign l2_addr       = addr_q;
    assign l2_write_data = wdata_q;
    assign p0_rdata      = rdata0_q;
    assign p1_rdata      = rdata1_q;
    assign timeout_err   = timeoutErr_q;

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single level-2 cache port between two level-1 requesters: port 0 (instruction cache refill) and port 1 (data cache refill and write-through).
- Registers one request at a time and drives the L2 read/write strobes, address and write data.
- Waits out the L2 stall during line fills, then returns the 128-bit half-line to the granted requester with a one-cycle ack.
- Round-robin arbitration, plus a watchdog that aborts reads the L2 never completes.

Parameters:
TIMEOUT_CYCLES, 64, maximum RD-state cycles with l2_stall high before the read is aborted (must be >= 16)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
p0_req  in  1  port 0 request; held high until p0_ack is seen
p0_we  in  1  port 0 write (1) / read (0)
p0_addr  in  32  port 0 word address
p0_wdata  in  32  port 0 write data
p0_ack  out  1  one-cycle completion pulse
p0_rdata  out  128  read block, valid while p0_ack=1
p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata  same as port 0, for port 1
l2_read_index  out  1  L2 read strobe
l2_write_index  out  1  L2 write strobe
l2_addr  out  32  registered request address
l2_write_data  out  32  registered write data
l2_stall  in  1  L2 busy filling a line
l2_block  in  128  L2 read block
busy  out  1  state != IDLE
grant_id  out  1  port currently or last served
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; last_grant=1, so port 0 wins the first tie. All outputs are 0, including rdata registers, l2_addr, l2_write_data and timeout_err. The watchdog counter is 0.
- The reset is honoured mid-transaction: the in-flight request is dropped, no ack is issued, and the requester must re-request.
- States are IDLE, RD, WR and RESP.
- IDLE:
  - Samples both reqs at each edge.
  - With a single req, that port is granted. With both, the port != last_grant is granted.
  - On grant: latch addr/wdata into l2_addr/l2_write_data, set grant_id and last_grant, clear the watchdog, then go to RD if we=0, else WR.
- RD:
  - l2_read_index=1 and l2_write_index=0 for the whole state.
  - At each edge with l2_stall=0: capture l2_block into the granted port's rdata register and go to RESP.
  - With l2_stall=1: increment the watchdog. If the watchdog reaches TIMEOUT_CYCLES-1, set timeout_err=1, load rdata with 0, drop the strobe and go to RESP.
- WR: l2_write_index=1 for exactly one cycle (the L2 write path never stalls), then go to RESP.
- RESP:
  - The granted port's ack=1 for exactly one cycle; the other ack stays 0. Both strobes are 0. Next state is IDLE.
  - The requester drops req at the edge that ends RESP, so the following IDLE cycle never re-grants a completed request.
- Latency: the grant edge is cycle 0, ack is high in cycle 2. A read hit or a write takes 2 cycles; a read miss takes 2 + N cycles, where N is the number of stall cycles.
- rdata holds its value until the next read completes on that port. l2_addr and l2_write_data hold until the next grant.
- In IDLE, l2_read_index and l2_write_index are 0. A request arriving while busy waits; reqs are not queued beyond the held level.
- timeout_err clears only on reset.
- The watchdog width is clog2(TIMEOUT_CYCLES) and it saturates; there is no wrap.

Test Plan:
- Read hit: p0_req=1, we=0, addr=0x40, l2_stall=0, l2_block=0xA5..A5 -> l2_read_index high 1 cycle, l2_addr=0x40, p0_ack in cycle 2, p0_rdata=0xA5..A5, p1_ack=0.
- Read miss: p1 read, l2_stall high 9 cycles -> l2_read_index high 10 cycles, p1_ack in cycle 11, p1_rdata=l2_block sampled on the first stall-low edge.
- Simultaneous: both ports request reads continuously from reset -> grant order 0,1,0,1. Each ack is exclusive, and busy drops for exactly one IDLE cycle between grants.
- Write: p1_we=1, addr=0x1C, wdata=0xDEADBEEF -> l2_write_index exactly 1 cycle with l2_write_data=0xDEADBEEF, p1_ack in cycle 2, p1_rdata unchanged.
- Timeout: TIMEOUT_CYCLES=16, l2_stall stuck high -> after 16 RD cycles timeout_err=1, ack pulses with rdata=0. The flag stays set through later transactions.
- Reset mid-miss: rst=0 during RD -> all outputs 0 immediately, no ack. After release, a port 0 request is granted first.
